// File: rtl/stack_sequencer.sv
// stack_sequencer: turns push/pop requests into stackpointer steps and stack-memory strobes.
// Build option STACK_PEEK_EN adds i_peek, a non-destructive read of the top word.
module stack_sequencer #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned CW    = 9
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_push,
   input  logic        i_pop,
`ifdef STACK_PEEK_EN
   input  logic        i_peek,
`endif
   input  logic [0:15] i_pushData,
   input  logic        i_spRead,
   input  logic [0:15] i_topAddr,
   input  logic [0:15] i_memRData,
   output logic [0:2]  o_spCtrl,
   output logic [0:15] o_memAddr,
   output logic [0:15] o_memWData,
   output logic        o_memWe,
   output logic        o_memRe,
   output logic        o_ready,
   output logic        o_popValid,
   output logic [0:15] o_popData,
   output logic        o_full,
   output logic        o_empty,
   output logic        o_err
);

`ifdef STACK_PEEK_EN
   typedef enum logic [2:0] {
      StIdle, StPushWr, StPushInc, StPopDec, StPopRd, StPopDone, StPeekRst
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StPushWr, StPushInc, StPopDec, StPopRd, StPopDone
   } state_e;
`endif

   localparam logic [CW-1:0] FullCount = CW'(DEPTH);
   localparam logic [CW-1:0] CntOne    = CW'(1);

   state_e        r_state;
   logic [CW-1:0] r_count;
   logic [0:1]    r_spStep;
   logic [0:15]   r_memWData;
   logic [0:15]   r_popData;
   logic          r_memWe;
   logic          r_memRe;
   logic          r_popValid;
   logic          r_err;
`ifdef STACK_PEEK_EN
   logic          r_isPeek;
`endif

   logic w_idle;
   logic w_full;
   logic w_empty;
   logic w_illegal;

   assign w_idle  = (r_state == StIdle);
   assign w_full  = (r_count == FullCount);
   assign w_empty = (r_count == '0);

`ifdef STACK_PEEK_EN
   assign w_illegal = (i_push && i_pop) || (i_push && w_full) || (i_pop && w_empty) ||
                      (i_peek && (w_empty || i_push || i_pop));
`else
   assign w_illegal = (i_push && i_pop) || (i_push && w_full) || (i_pop && w_empty);
`endif

   // Strobes are registered on entry to the state that owns them, so each lasts one state.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_count    <= '0;
         r_spStep   <= 2'b00;
         r_memWData <= 16'h0000;
         r_popData  <= 16'h0000;
         r_memWe    <= 1'b0;
         r_memRe    <= 1'b0;
         r_popValid <= 1'b0;
         r_err      <= 1'b0;
`ifdef STACK_PEEK_EN
         r_isPeek   <= 1'b0;
`endif
      end else begin
         r_spStep   <= 2'b00;
         r_memWe    <= 1'b0;
         r_memRe    <= 1'b0;
         r_popValid <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_illegal) begin
                  r_err <= 1'b1;
               end else if (i_push) begin
                  r_memWData <= i_pushData;
                  r_memWe    <= 1'b1;
                  r_state    <= StPushWr;
               end else if (i_pop) begin
                  r_spStep <= 2'b10;
                  r_state  <= StPopDec;
`ifdef STACK_PEEK_EN
               end else if (i_peek) begin
                  r_spStep <= 2'b10;
                  r_isPeek <= 1'b1;
                  r_state  <= StPopDec;
`endif
               end
            end
            StPushWr: begin
               r_spStep <= 2'b01;
               r_state  <= StPushInc;
            end
            StPushInc: begin
               r_count <= r_count + CntOne;
               r_state <= StIdle;
            end
            StPopDec: begin
`ifdef STACK_PEEK_EN
               if (!r_isPeek) r_count <= r_count - CntOne;
`else
               r_count <= r_count - CntOne;
`endif
               r_memRe <= 1'b1;
               r_state <= StPopRd;
            end
            StPopRd: begin
               r_state <= StPopDone;
            end
            StPopDone: begin
               r_popData  <= i_memRData;
               r_popValid <= 1'b1;
`ifdef STACK_PEEK_EN
               if (r_isPeek) begin
                  r_spStep <= 2'b01;
                  r_isPeek <= 1'b0;
                  r_state  <= StPeekRst;
               end else begin
                  r_state <= StIdle;
               end
            end
            StPeekRst: begin
               r_state <= StIdle;
`else
               r_state <= StIdle;
`endif
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_spCtrl   = {w_idle & i_spRead, r_spStep};
   assign o_memAddr  = i_topAddr;
   assign o_memWData = r_memWData;
   assign o_memWe    = r_memWe;
   assign o_memRe    = r_memRe;
   assign o_ready    = w_idle;
   assign o_popValid = r_popValid;
   assign o_popData  = r_popData;
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_err      = r_err;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a stackpointer/memory model and a pop-data scoreboard.
module tb_stack_sequencer;
   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic        sp_read = 1'b0;
`ifdef STACK_PEEK_EN
   logic        peek = 1'b0;
`endif
   logic [15:0] push_data = 16'h0000;
   logic [15:0] mem_rdata = 16'h0000;
   logic [15:0] top_addr;
   logic [2:0]  sp_ctrl;
   logic [15:0] mem_addr, mem_wdata, pop_data;
   logic        mem_we, mem_re, ready, pop_valid, full, empty, err;

   logic [15:0] sp = 16'h0100;
   logic [15:0] mem [0:4095];
   logic [15:0] model[$];
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;
   logic [15:0] sp0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          lat;

   stack_sequencer #(.DEPTH(DEPTH), .CW(9)) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_push     (push),
      .i_pop      (pop),
`ifdef STACK_PEEK_EN
      .i_peek     (peek),
`endif
      .i_pushData (push_data),
      .i_spRead   (sp_read),
      .i_topAddr  (top_addr),
      .i_memRData (mem_rdata),
      .o_spCtrl   (sp_ctrl),
      .o_memAddr  (mem_addr),
      .o_memWData (mem_wdata),
      .o_memWe    (mem_we),
      .o_memRe    (mem_re),
      .o_ready    (ready),
      .o_popValid (pop_valid),
      .o_popData  (pop_data),
      .o_full     (full),
      .o_empty    (empty),
      .o_err      (err)
   );

   always #5 clk = ~clk;

   // Stackpointer and stack memory as seen by the sequencer.
   assign top_addr = sp;
   always @(posedge clk) begin
      if (sp_ctrl[1:0] == 2'b01) sp <= sp + 16'd1;
      else if (sp_ctrl[1:0] == 2'b10) sp <= sp - 16'd1;
      if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[11:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (pop_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("pop_unexpected", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("pop_data", {16'h0, pop_data}, {16'h0, mon_exp});
         end
      end
   end

   task automatic wait_ready(output int cycles);
      cycles = 1;
      while (ready !== 1'b1 && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic do_push(input logic [15:0] d, output int cycles);
      push = 1'b1; push_data = d;
      @(posedge clk); #1;
      push = 1'b0;
      model.push_back(d);
      wait_ready(cycles);
   endtask

   task automatic do_pop(output int cycles);
      pop = 1'b1;
      @(posedge clk); #1;
      pop = 1'b0;
      if (model.size() > 0) exp_q.push_back(model.pop_back());
      wait_ready(cycles);
   endtask

   task automatic err_req(input string tag, input logic p, input logic q);
      logic [15:0] s;
      s = sp;
      push = p; pop = q;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
      check({tag, "_err"}, err, 1);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_ctrl"}, sp_ctrl, 0);
      check({tag, "_strobes"}, {mem_we, mem_re}, 0);
      @(posedge clk); #1;
      check({tag, "_err_clr"}, err, 0);
      check({tag, "_sp"}, sp, s);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset state
      @(posedge clk); #1;
      check("rst_ready", ready, 1);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ctrl", sp_ctrl, 0);
      check("rst_strobes", {mem_we, mem_re, pop_valid, err}, 0);
      check("rst_popdata", pop_data, 16'h0000);
      check("rst_wdata", mem_wdata, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_ready", ready, 1);

      // 2. push BEEF at SP=0x0100, cycle by cycle
      push = 1'b1; push_data = 16'hBEEF;
      @(posedge clk); #1;
      push = 1'b0;
      model.push_back(16'hBEEF);
      check("pw_we", mem_we, 1);
      check("pw_addr", mem_addr, 16'h0100);
      check("pw_wdata", mem_wdata, 16'hBEEF);
      check("pw_ctrl", sp_ctrl, 0);
      check("pw_ready", ready, 0);
      @(posedge clk); #1;
      check("pi_ctrl", sp_ctrl, 3'b001);
      check("pi_we", mem_we, 0);
      check("pi_ready", ready, 0);
      @(posedge clk); #1;
      check("push_ready3", ready, 1);
      check("push_empty", empty, 0);
      check("push_sp", sp, 16'h0101);
      check("push_mem", mem[12'h100], 16'hBEEF);
      do_pop(lat);
      check("pop_lat", lat, 4);
      check("pop_sp", sp, 16'h0100);
      check("pop_empty", empty, 1);

      // bus-drive request only honoured in IDLE
      sp_read = 1'b1;
      #1;
      check("spread_idle", sp_ctrl, 3'b100);
      push = 1'b1; push_data = 16'h0077;
      @(posedge clk); #1;
      push = 1'b0;
      model.push_back(16'h0077);
      check("spread_busy", sp_ctrl, 3'b000);
      sp_read = 1'b0;
      wait_ready(lat);
      do_pop(lat);

      // 3. LIFO ordering
      do_push(16'h00A1, lat);
      check("push_lat", lat, 3);
      do_push(16'h00A2, lat);
      do_pop(lat);
      check("pv_pulse", pop_valid, 1);
      @(posedge clk); #1;
      check("pv_clear", pop_valid, 0);
      check("pd_held", pop_data, 16'h00A2);
      do_pop(lat);
      @(posedge clk); #1;
      check("lifo_empty", empty, 1);
      check("lifo_sp", sp, 16'h0100);

      // 4. illegal requests
      err_req("pop_empty", 1'b0, 1'b1);
      err_req("push_pop", 1'b1, 1'b1);
      for (int i = 0; i < DEPTH; i++) do_push(16'h5A00 ^ 16'(i), lat);
      check("fill_full", full, 1);
      check("fill_sp", sp, 16'h0200);
      err_req("push_full", 1'b1, 1'b0);
      err_req("pp_full", 1'b1, 1'b1);
      check("still_full", full, 1);
      for (int i = 0; i < DEPTH; i++) do_pop(lat);
      check("drain_empty", empty, 1);
      check("drain_sp", sp, 16'h0100);

      // 5. reset during PUSH_WR
      push = 1'b1; push_data = 16'h5555;
      @(posedge clk); #1;
      push = 1'b0;
      check("rw_we", mem_we, 1);
      rst = 1'b1;
      #1;
      check("rw_we_drop", mem_we, 0);
      check("rw_ready", ready, 1);
      check("rw_empty", empty, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rw_sp", sp, 16'h0100);
      do_push(16'h0F0F, lat);
      do_pop(lat);

`ifdef STACK_PEEK_EN
      // 6. peek leaves SP and count unchanged
      do_push(16'h1234, lat);
      sp0 = sp;
      peek = 1'b1;
      @(posedge clk); #1;
      peek = 1'b0;
      exp_q.push_back(16'h1234);
      wait_ready(lat);
      check("peek_lat", lat, 5);
      check("peek_sp", sp, sp0);
      check("peek_empty", empty, 0);
      peek = 1'b1; push = 1'b1;
      @(posedge clk); #1;
      peek = 1'b0; push = 1'b0;
      check("peek_push_err", err, 1);
      do_pop(lat);
      peek = 1'b1;
      @(posedge clk); #1;
      peek = 1'b0;
      check("peek_empty_err", err, 1);
      check("peek_empty_ready", ready, 1);
`endif

      @(posedge clk); #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
